// File: rtl/mips_multicycle_ctrl_pkg.sv
// rtl/mips_multicycle_ctrl_pkg.sv - states, opcodes, control codes and strobe decode for the multicycle MIPS controller
package mips_multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_TRAP    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   typedef struct packed {
      logic       mem_req;
      logic       mem_wr;
      logic       iord;
      logic       ir_wr;
      logic       pc_wr;
      logic [1:0] pc_src;
      logic       reg_wr;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic logic is_mem_wait(state_t st);
      return (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
   endfunction

   function automatic state_t dispatch(logic [5:0] op);
      case (op)
         OP_RTYPE:     return S_EXEC;
         OP_LW, OP_SW: return S_MEMADR;
         OP_BEQ:       return S_BRANCH;
         OP_ADDI:      return S_ADDIEX;
         OP_J:         return S_JUMP;
         default:      return S_TRAP;
      endcase
   endfunction

   // TRAP and any unlisted field fall through to the all-zero default.
   function automatic ctrl_t ctrl_decode(state_t st, logic mem_ready, logic alu_zero);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH: begin
            c.mem_req   = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALU_ADD;
            c.pc_src    = PC_ALU;
            c.ir_wr     = mem_ready;
            c.pc_wr     = mem_ready;
         end
         S_DECODE: c.alu_src_b = SRCB_IMM_SH;
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEMWB: begin
            c.reg_wr     = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            c.mem_req = 1'b1;
            c.mem_wr  = 1'b1;
            c.iord    = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_RT;
            c.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            c.reg_wr  = 1'b1;
            c.reg_dst = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_SUB;
            c.pc_src    = PC_ALUOUT;
            c.pc_wr     = alu_zero;
         end
         S_ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_ADDIWB: c.reg_wr = 1'b1;
         S_JUMP: begin
            c.pc_src = PC_JUMP;
            c.pc_wr  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_timer.sv
// rtl/mips_multicycle_ctrl_timer.sv - memory wait counter; pulses timeout on the cycle that would reach LIMIT
module mem_wait_timer #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic timeout
);

   logic [7:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en) begin
         count <= count + 8'd1;
      end
   end

   // Only asserted on a stalled cycle, so a ready on the limit cycle never traps.
   assign timeout = count_en && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM sequencing the shared multicycle MIPS datapath
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int RET_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_wr,
   output logic             iord,
   output logic             ir_wr,
   output logic             pc_wr,
   output logic [1:0]       pc_src,
   output logic             reg_wr,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [RET_W-1:0] retired,
   output logic             err,
   output logic [3:0]       state
);

   localparam logic [RET_W-1:0] RET_ONE = RET_W'(1);

   state_t state_q;
   state_t next_op;
   ctrl_t  ctrl;
   logic   count_en;
   logic   timeout;

   assign count_en = is_mem_wait(state_q) && !mem_ready;
   assign next_op  = dispatch(opcode);

   mem_wait_timer #(
      .LIMIT(MEM_TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (!count_en),
      .count_en (count_en),
      .timeout  (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         retired <= '0;
         err     <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ready) begin
                  state_q <= S_DECODE;
               end else if (timeout) begin
                  state_q <= S_TRAP;
                  err     <= 1'b1;
               end
            end
            S_DECODE: begin
               state_q <= next_op;
               if (next_op == S_TRAP) err <= 1'b1;
            end
            S_MEMADR: state_q <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
               if (mem_ready) begin
                  state_q <= S_MEMWB;
               end else if (timeout) begin
                  state_q <= S_TRAP;
                  err     <= 1'b1;
               end
            end
            S_MEMWR: begin
               if (mem_ready) begin
                  state_q <= S_FETCH;
                  retired <= retired + RET_ONE;
               end else if (timeout) begin
                  state_q <= S_TRAP;
                  err     <= 1'b1;
               end
            end
            S_EXEC:   state_q <= S_ALUWB;
            S_ADDIEX: state_q <= S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
               state_q <= S_FETCH;
               retired <= retired + RET_ONE;
            end
            S_TRAP:   state_q <= S_TRAP;
            default:  state_q <= S_TRAP;
         endcase
      end
   end

   // Strobes drop the moment rst rises, even though FETCH would otherwise request memory.
   always_comb begin
      ctrl = ctrl_decode(state_q, mem_ready, alu_zero);
      if (rst) ctrl = '0;
   end

   assign mem_req    = ctrl.mem_req;
   assign mem_wr     = ctrl.mem_wr;
   assign iord       = ctrl.iord;
   assign ir_wr      = ctrl.ir_wr;
   assign pc_wr      = ctrl.pc_wr;
   assign pc_src     = ctrl.pc_src;
   assign reg_wr     = ctrl.reg_wr;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign state      = state_q;

endmodule
